// File: rtl/data_mem_stream_loader.sv
// Byte-stream loader for the on-chip data memory: packs valid/ready bytes little-endian into
// 32-bit words, writes them to consecutive addresses and reports count, checksum and overflow.
module data_mem_stream_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [31:0]           checksum
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic [3:0]            be_q, be_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [31:0]           checksum_q, checksum_d;
    logic                  error_q, error_d;

    // Byte lanes filled by a word whose final byte sits in lane idx.
    function automatic logic [3:0] lanes_upto(input logic [1:0] idx);
        logic [3:0] lanes;
        case (idx)
            2'd0:    lanes = 4'b0001;
            2'd1:    lanes = 4'b0011;
            2'd2:    lanes = 4'b0111;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        be_d         = be_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        error_d      = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = start_addr;
                    byte_idx_d   = 2'd0;
                    word_d       = 32'd0;
                    last_d       = 1'b0;
                    word_count_d = {(ADDR_WIDTH+1){1'b0}};
                    checksum_d   = 32'd0;
                    error_d      = 1'b0;
                    state_d      = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3 || in_last) begin
                        be_d    = lanes_upto(byte_idx_q);
                        last_d  = in_last;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WRITE: begin
                checksum_d   = checksum_q + word_q;
                word_count_d = word_count_q + CNT_ONE;
                byte_idx_d   = 2'd0;
                word_d       = 32'd0;
                if (last_q) begin
                    state_d = ST_DONE;
                end else if (addr_q == LAST_ADDR) begin
                    // Image runs past the top of memory: swallow the rest of the stream.
                    error_d = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (in_valid && in_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
            be_q         <= 4'd0;
            last_q       <= 1'b0;
            word_count_q <= {(ADDR_WIDTH+1){1'b0}};
            checksum_q   <= 32'd0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            be_q         <= be_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            error_q      <= error_d;
        end
    end

    // Output decode from the state register only; no input-to-output paths.
    always_comb begin
        in_ready       = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = {ADDR_WIDTH{1'b0}};
        mem_byteenable = 4'd0;
        mem_writedata  = 32'd0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            ST_FILL, ST_DRAIN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = addr_q;
                mem_byteenable = be_q;
                mem_writedata  = word_q;
                busy           = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign mem_clken  = 1'b1;
    assign error      = error_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_data_mem_stream_loader.sv
// Randomized bench for data_mem_stream_loader: each load is predicted from the byte image by a
// word-level model (addresses, lanes, checksum, overflow, done latency) and compared to the bus.
module tb_data_mem_stream_loader;

    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_last;
    logic [AW-1:0] start_addr;
    logic [7:0]    in_data;
    logic          in_ready, mem_chipselect, mem_write, mem_clken, busy, done, error;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_writedata, checksum;
    logic [AW:0]   word_count;

    data_mem_stream_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .busy(busy), .done(done), .error(error), .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records every write and counts protocol violations.
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    logic [3:0]    obs_be[$];
    int            bus_viol = 0;
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            obs_addr.push_back(mem_address);
            obs_data.push_back(mem_writedata);
            obs_be.push_back(mem_byteenable);
        end
        if (mem_write === 1'b1 && in_ready !== 1'b0) bus_viol++;
        if (mem_chipselect !== mem_write) bus_viol++;
        if (mem_write !== 1'b1 && (mem_address !== '0 || mem_byteenable !== 4'd0 || mem_writedata !== 32'd0))
            bus_viol++;
        if (mem_clken !== 1'b1) bus_viol++;
    end

    logic [7:0] img[$];

    task automatic fill_seq(input int n, input logic [7:0] first, input logic [7:0] step);
        logic [7:0] b;
        img.delete();
        b = first;
        for (int i = 0; i < n; i++) begin
            img.push_back(b);
            b = b + step;
        end
    endtask

    task automatic fill_rand(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    // One load of img from addr; abort_after>0 resets the DUT once that many bytes are accepted.
    task automatic do_load(input logic [AW-1:0] addr, input bit gaps, input bit restart_mid,
                           input int abort_after, input string tag);
        logic [AW-1:0] exp_addr[$];
        logic [31:0]   exp_data[$];
        logic [3:0]    exp_be[$];
        logic [31:0]   exp_sum, w;
        logic [3:0]    be;
        bit            exp_err, got_done;
        int            n, n_model, nwords, a, i, guard, exp_lat;
        int unsigned   last_cyc;

        n = img.size();
        n_model = (abort_after > 0) ? (abort_after / 4) * 4 : n;
        nwords = (n_model + 3) / 4;
        exp_sum = 32'd0;
        exp_err = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            a = int'(addr) + k;
            w = 32'd0;
            be = 4'd0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n_model) begin
                    w = w | (32'(img[4 * k + j]) << (8 * j));
                    be[j] = 1'b1;
                end
            end
            if (a > DEPTH - 1) begin
                exp_err = 1'b1;
            end else begin
                exp_addr.push_back(AW'(a));
                exp_data.push_back(w);
                exp_be.push_back(be);
                exp_sum = exp_sum + w;
            end
        end
        exp_lat = exp_err ? 1 : 2;

        obs_addr.delete();
        obs_data.delete();
        obs_be.delete();

        @(posedge clk); #1;
        start = 1'b1;
        start_addr = addr;
        @(posedge clk); #1;
        start = 1'b0;
        start_addr = AW'($urandom);
        check_val({tag, " busy_after_start"}, 32'(busy), 32'd1);

        i = 0;
        guard = 0;
        last_cyc = 0;
        while (i < n && !(abort_after > 0 && i >= abort_after) && guard < 2000) begin
            guard++;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = in_valid ? img[i] : 8'($urandom);
            in_last  = in_valid && (i == n - 1);
            if (restart_mid && i == n / 2) begin
                start = 1'b1;
                start_addr = 12'h300;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (i == n - 1) last_cyc = cyc;
                i++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        start = 1'b0;

        if (abort_after > 0) begin
            check_val({tag, " bytes_before_abort"}, 32'(i), 32'(abort_after));
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check_val({tag, " busy_after_reset"}, 32'(busy), 32'd0);
            check_val({tag, " ready_after_reset"}, 32'(in_ready), 32'd0);
            check_val({tag, " count_after_reset"}, 32'(word_count), 32'd0);
            repeat (8) @(posedge clk);
            #1;
        end else begin
            check_val({tag, " bytes_accepted"}, 32'(i), 32'(n));
            got_done = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    got_done = 1'b1;
                    break;
                end
            end
            check_val({tag, " done_seen"}, 32'(got_done), 32'd1);
            if (got_done) begin
                check_val({tag, " done_latency"}, 32'(cyc - last_cyc), 32'(exp_lat));
                check_val({tag, " busy_at_done"}, 32'(busy), 32'd0);
                @(negedge clk);
                check_val({tag, " done_one_cycle"}, 32'(done), 32'd0);
                check_val({tag, " word_count"}, 32'(word_count), 32'(exp_addr.size()));
                check_val({tag, " checksum"}, checksum, exp_sum);
                check_val({tag, " error"}, 32'(error), 32'(exp_err));
            end else begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
            end
        end

        check_val({tag, " write_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
            check_val({tag, " wr_addr"}, 32'(obs_addr[k]), 32'(exp_addr[k]));
            check_val({tag, " wr_data"}, obs_data[k], exp_data[k]);
            check_val({tag, " wr_be"}, 32'(obs_be[k]), 32'(exp_be[k]));
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        in_valid = 1'b0;
        in_data = 8'd0;
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst in_ready", 32'(in_ready), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst error", 32'(error), 32'd0);
        check_val("rst word_count", 32'(word_count), 32'd0);
        check_val("rst checksum", checksum, 32'd0);
        check_val("rst mem_write", 32'(mem_write), 32'd0);
        check_val("rst mem_clken", 32'(mem_clken), 32'd1);
        reset = 1'b0;

        fill_seq(8, 8'h11, 8'h11);
        do_load(12'h010, 1'b0, 1'b0, 0, "two_words");
        check_val("two_words checksum_const", checksum, 32'hCCAA8866);

        fill_seq(3, 8'hAA, 8'h11);
        do_load(12'h020, 1'b0, 1'b0, 0, "partial");
        check_val("partial checksum_const", checksum, 32'h00CCBBAA);

        fill_seq(8, 8'h01, 8'h01);
        do_load(12'hFFF, 1'b0, 1'b0, 0, "overflow");
        check_val("overflow error_const", 32'(error), 32'd1);

        fill_seq(4, 8'hC1, 8'h01);
        do_load(12'hFFF, 1'b1, 1'b0, 0, "top_exact");

        fill_rand(12);
        do_load(12'h100, 1'b1, 1'b0, 0, "gaps");

        fill_rand(12);
        do_load(12'h180, 1'b1, 1'b0, 6, "abort");

        fill_rand(4);
        do_load(12'h200, 1'b0, 1'b0, 0, "after_abort");

        fill_rand(10);
        do_load(12'h050, 1'b1, 1'b1, 0, "restart_ignored");

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 3) == 0) ra = AW'(DEPTH - int'($urandom_range(1, 3)));
            else ra = AW'($urandom);
            fill_rand(int'($urandom_range(1, 20)));
            do_load(ra, 1'b1, 1'b0, 0, "random");
        end

        check_val("bus protocol violations", 32'(bus_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_stream_loader.md
Name: data_mem_stream_loader

Overview:
- Upstream feeder for the 4096 x 32-bit single-port on-chip data memory.
- Accepts a byte stream from a test/debug source (scan/UART bridge) using a valid/ready handshake.
- Packs bytes little-endian into 32-bit words and writes them to consecutive memory addresses from a programmed start address.
- Reports word count, a 32-bit additive checksum, overflow error and a done pulse, so DFT software can preload memory images and check them.

Parameters:
- ADDR_WIDTH, 12: word-address width of the target memory.
- DEPTH, 4096: number of words in the target memory; the last valid address is DEPTH-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE.
- start_addr  input  ADDR_WIDTH  first word address, latched on an accepted start.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_last  input  1  marks the final byte of the image; qualified by in_valid.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_chipselect  output  1  memory chipselect.
- mem_write  output  1  memory write strobe.
- mem_address  output  ADDR_WIDTH  memory word address.
- mem_byteenable  output  4  memory byte lanes.
- mem_writedata  output  32  memory write data.
- mem_clken  output  1  memory clock enable; tied to 1.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at the end of a load.
- error  output  1  overflow flag; held until the next accepted start.
- word_count  output  ADDR_WIDTH+1  number of words written in the current/last load.
- checksum  output  32  sum mod 2^32 of all written words; partial words are zero-padded.

Behaviour:
- Reset: all outputs 0 except mem_clken=1; FSM goes to IDLE. Reset mid-load aborts immediately. A pending partial word is discarded and never written.
- FSM states: IDLE, FILL, WRITE, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - On start: latch start_addr into addr; clear byte_idx, word_count, checksum and error; go to FILL.
  - busy=1 from the next cycle.
- FILL:
  - in_ready=1.
  - An accepted byte (in_valid & in_ready) goes to lane byte_idx (byte 0 -> bits 7:0); byte_idx increments.
  - If that byte is the 4th byte or has in_last=1, go to WRITE with be = lower (byte_idx+1) bits set. Example: 2 bytes -> 4'b0011.
- WRITE (exactly one cycle):
  - in_ready=0; mem_chipselect=1, mem_write=1, mem_address=addr, mem_byteenable=be, mem_writedata=packed word with unused lanes 0.
  - Checksum += word; word_count += 1; byte_idx cleared.
  - Next state: DONE if the word held the last byte. Otherwise, if addr==DEPTH-1, set error=1 and go to DRAIN. Otherwise addr+1, back to FILL.
  - The memory has no waitrequest; the write completes in this cycle.
- DRAIN:
  - in_ready=1.
  - Bytes are accepted and dropped; no memory access.
  - Go to DONE on an accepted byte with in_last=1.
- DONE:
  - done=1 for one cycle; busy drops the same cycle; go to IDLE.
  - word_count, checksum and error hold until the next start.
- Outside WRITE: mem_chipselect=0, mem_write=0; mem_byteenable, mem_writedata and mem_address are don't-care but driven to 0.
- Throughput: one full word per 5 cycles at continuous in_valid.
- Latency: 4th byte accepted at cycle N -> memory write at cycle N+1 -> done at N+2 if last.
- start asserted while busy is ignored.
- in_last on the 4th byte produces one full-word write, never an extra empty write.
- in_last is never asserted without in_valid; if it is, it has no effect.
- A zero-length load is impossible: the FSM waits in FILL for at least one byte.

Test Plan:
- start_addr=0x010, bytes 11 22 33 44 55 66 77 88 (last on 88) -> mem[0x010]=0x44332211 be=F, mem[0x011]=0x88776655 be=F; word_count=2, checksum=0xCCAA8866, done pulse 2 cycles after byte 88 accepted.
- start_addr=0x020, bytes AA BB CC (last on CC) -> single write mem[0x020]=0x00CCBBAA, be=4'b0111; word_count=1, checksum=0x00CCBBAA, error=0.
- start_addr=0xFFF, 8 bytes 01..08 (last on 08) -> mem[0xFFF]=0x04030201, error=1, bytes 05..08 drained with in_ready=1 and no writes; word_count=1, done pulse.
- Random in_valid gaps with a 12-byte image at start_addr=0x100 -> three writes at 0x100..0x102 with correct data; in_ready=0 exactly in WRITE cycles; no writes while in_valid low.
- Reset asserted after 6 bytes of a load -> next cycle busy=0, in_ready=0, no write of the partial word; subsequent start at 0x200 with 4 bytes writes only mem[0x200].
- start pulsed again mid-load at start_addr=0x300 -> ignored; addresses continue from the original start_addr.
